// File: rtl/rvv_pkg.sv
// rvv_pkg: vector-unit encodings shared by the issue logic,
// the lane sequencer and the ALU.
package rvv_pkg;

   localparam logic [2:0] OPT_VV = 3'b001;
   localparam logic [2:0] OPT_VX = 3'b010;
   localparam logic [2:0] OPT_VI = 3'b100;

   localparam logic [5:0] F6_VADD = 6'b000000;
   localparam logic [5:0] F6_VSUB = 6'b000010;
   localparam logic [5:0] F6_VAND = 6'b001001;
   localparam logic [5:0] F6_VOR  = 6'b001010;
   localparam logic [5:0] F6_VXOR = 6'b001011;

   // SEW in bits for a legal vsew encoding
   function automatic logic [6:0] sew_bits(input logic [1:0] vsew);
      return 7'd8 << vsew;
   endfunction

endpackage

// File: rtl/rvv_alu_seq.sv
// rvv_alu_seq: steps one rvv_alu lane over a latched vector op and
// gathers the lane results into a VLEN-bit destination register.
module rvv_alu_seq
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic [5:0]      opcode_in,
   input  logic [2:0]      op_type_in,
   input  logic [2:0]      vsew_in,
   input  logic [9:0]      vl_in,
   input  logic [VLEN-1:0] vs1_in,
   input  logic [VLEN-1:0] vs2_in,
   input  logic [VLEN-1:0] vd_old,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [VLEN-1:0] vd_out,
   output logic            alu_run,
   output logic [5:0]      alu_opcode,
   output logic [2:0]      alu_op_type,
   output logic [2:0]      alu_vsew,
   output logic [VLEN-1:0] alu_vs1,
   output logic [VLEN-1:0] alu_vs2,
   output logic [9:0]      alu_index,
   output logic [3:0]      alu_in_reg_offset,
   output logic [1:0]      alu_nb_lanes,
   input  logic [63:0]     alu_vd
);

   localparam int unsigned LW = 1 << LANE_WIDTH;
   localparam logic [VLEN-1:0] LANE_ONES = (VLEN'(1) << LW) - VLEN'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      r_state;
   logic [5:0]      r_opcode;
   logic [2:0]      r_op_type;
   logic [2:0]      r_vsew;
   logic [VLEN-1:0] r_vs1;
   logic [VLEN-1:0] r_vs2;
   logic [VLEN-1:0] r_vd;
   logic [9:0]      r_index;
   logic [3:0]      r_off;
   logic [10:0]     r_total;
   logic            r_err;

   logic [2:0]      w_sh;
   logic [10:0]     w_vlmax;
   logic [10:0]     w_vleff;
   logic [10:0]     w_total;
   logic [6:0]      w_sew;
   logic [6:0]      w_ratio;
   logic [3:0]      w_off_max;
   logic            w_wide;
   logic [10:0]     w_next;
   logic [VLEN-1:0] w_mask;
   logic [VLEN-1:0] w_data;

   // op setup: clamp vl to VLMAX and size the active bit range
   assign w_sh    = {1'b0, vsew_in[1:0]} + 3'd3;
   assign w_vlmax = 11'(VLEN) >> w_sh;
   assign w_vleff = ({1'b0, vl_in} < w_vlmax) ? {1'b0, vl_in} : w_vlmax;
   assign w_total = w_vleff << w_sh;

   // elements wider than the lane take several chunks; the ALU carries on r_off
   assign w_sew     = sew_bits(r_vsew[1:0]);
   assign w_ratio   = w_sew >> LANE_WIDTH;
   assign w_off_max = 4'(w_ratio - 7'd1);
   assign w_wide    = w_sew > 7'(LW);
   assign w_next    = {1'b0, r_index} + 11'(LW);

   assign w_mask = (LANE_ONES << r_index) & ~({VLEN{1'b1}} << r_total);
   assign w_data = VLEN'(alu_vd[LW-1:0]) << r_index;

   if (LW < 64) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^alu_vd[63:LW];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_opcode  <= '0;
         r_op_type <= '0;
         r_vsew    <= '0;
         r_vs1     <= '0;
         r_vs2     <= '0;
         r_vd      <= '0;
         r_index   <= '0;
         r_off     <= '0;
         r_total   <= '0;
         r_err     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_opcode  <= opcode_in;
                  r_op_type <= op_type_in;
                  r_vsew    <= vsew_in;
                  r_vs1     <= vs1_in;
                  r_vs2     <= vs2_in;
                  r_vd      <= vd_old;
                  r_index   <= '0;
                  r_off     <= '0;
                  r_total   <= w_total;
                  r_err     <= vsew_in[2];
                  r_state   <= (vsew_in[2] || vl_in == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               r_vd    <= (r_vd & ~w_mask) | (w_data & w_mask);
               r_index <= r_index + 10'(LW);
               if (!w_wide || r_off == w_off_max)
                  r_off <= '0;
               else
                  r_off <= r_off + 4'd1;
               if (w_next >= r_total)
                  r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy              = r_state != S_IDLE;
   assign done              = r_state == S_DONE;
   assign alu_run           = r_state == S_RUN;
   assign err               = r_err;
   assign vd_out            = r_vd;
   assign alu_opcode        = r_opcode;
   assign alu_op_type       = r_op_type;
   assign alu_vsew          = r_vsew;
   assign alu_vs1           = r_vs1;
   assign alu_vs2           = r_vs2;
   assign alu_index         = r_index;
   assign alu_in_reg_offset = r_off;
   assign alu_nb_lanes      = 2'b00;

endmodule

// File: tb/tb_rvv_alu_seq.sv
// tb_rvv_alu_seq: scoreboard bench for rvv_alu_seq at LW=8 and LW=16,
// with a behavioural element-wise ALU closing the alu_vd loop.
module tb_rvv_alu_seq;
   import rvv_pkg::*;

   typedef struct {
      logic [127:0] vd;
      logic         err;
      int           runs;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         resetn;
   logic         start8, start16;
   logic [5:0]   opcode_in;
   logic [2:0]   op_type_in, vsew_in;
   logic [9:0]   vl_in;
   logic [127:0] vs1_in, vs2_in, vd_old;

   logic         busy8, done8, err8, run8;
   logic [127:0] vd8, a8, b8;
   logic [5:0]   op8;
   logic [2:0]   ot8, sw8;
   logic [9:0]   idx8;
   logic [3:0]   off8;
   logic [1:0]   nbl8;
   logic [63:0]  alu_vd8;

   logic         busy16, done16, err16, run16;
   logic [127:0] vd16, a16, b16;
   logic [5:0]   op16;
   logic [2:0]   ot16, sw16;
   logic [9:0]   idx16;
   logic [3:0]   off16;
   logic [1:0]   nbl16;
   logic [63:0]  alu_vd16;

   bit           sel;
   logic         m_busy, m_done, m_err, m_run;
   logic [127:0] m_vd;
   logic [9:0]   m_idx;
   logic [3:0]   m_off;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   rvv_alu_seq #(.VLEN(128), .LANE_WIDTH(3)) u8 (
      .clk(clk), .resetn(resetn), .start(start8),
      .opcode_in(opcode_in), .op_type_in(op_type_in),
      .vsew_in(vsew_in), .vl_in(vl_in),
      .vs1_in(vs1_in), .vs2_in(vs2_in), .vd_old(vd_old),
      .busy(busy8), .done(done8), .err(err8), .vd_out(vd8),
      .alu_run(run8), .alu_opcode(op8), .alu_op_type(ot8),
      .alu_vsew(sw8), .alu_vs1(a8), .alu_vs2(b8),
      .alu_index(idx8), .alu_in_reg_offset(off8),
      .alu_nb_lanes(nbl8), .alu_vd(alu_vd8)
   );

   rvv_alu_seq #(.VLEN(128), .LANE_WIDTH(4)) u16 (
      .clk(clk), .resetn(resetn), .start(start16),
      .opcode_in(opcode_in), .op_type_in(op_type_in),
      .vsew_in(vsew_in), .vl_in(vl_in),
      .vs1_in(vs1_in), .vs2_in(vs2_in), .vd_old(vd_old),
      .busy(busy16), .done(done16), .err(err16), .vd_out(vd16),
      .alu_run(run16), .alu_opcode(op16), .alu_op_type(ot16),
      .alu_vsew(sw16), .alu_vs1(a16), .alu_vs2(b16),
      .alu_index(idx16), .alu_in_reg_offset(off16),
      .alu_nb_lanes(nbl16), .alu_vd(alu_vd16)
   );

   // whole-register element-wise result, vs2 op vs1
   function automatic logic [127:0] full_op(input logic [5:0] op,
         input logic [2:0] sw, input logic [127:0] a, input logic [127:0] b);
      logic [127:0] res;
      logic [63:0]  m, x, y, r;
      int           sew;
      sew = 8 << sw[1:0];
      m   = (sew == 64) ? '1 : (64'd1 << sew) - 64'd1;
      res = '0;
      for (int i = 0; i < 128 / sew; i++) begin
         x = 64'(a >> (i * sew)) & m;
         y = 64'(b >> (i * sew)) & m;
         case (op)
            F6_VADD: r = y + x;
            F6_VSUB: r = y - x;
            F6_VAND: r = y & x;
            F6_VOR:  r = y | x;
            default: r = y ^ x;
         endcase
         res = res | (128'(r & m) << (i * sew));
      end
      return res;
   endfunction

   function automatic exp_t model(input logic [5:0] op, input logic [2:0] sw,
         input logic [9:0] vl, input logic [127:0] a, input logic [127:0] b,
         input logic [127:0] old, input int lw);
      exp_t         e;
      int           sew, vle;
      logic [127:0] keep;
      e.vd   = old;
      e.err  = sw[2];
      e.runs = 0;
      if (sw[2]) return e;
      sew  = 8 << sw[1:0];
      vle  = (int'(vl) < 128 / sew) ? int'(vl) : 128 / sew;
      keep = (vle * sew >= 128) ? '0 : ({128{1'b1}} << (vle * sew));
      e.vd   = (old & keep) | (full_op(op, sw, a, b) & ~keep);
      e.runs = (vle * sew + lw - 1) / lw;
      return e;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always_comb begin
      alu_vd8  = 64'(full_op(op8, sw8, a8, b8) >> idx8);
      alu_vd16 = 64'(full_op(op16, sw16, a16, b16) >> idx16);
   end

   always_comb begin
      m_busy = sel ? busy16 : busy8;
      m_done = sel ? done16 : done8;
      m_err  = sel ? err16  : err8;
      m_run  = sel ? run16  : run8;
      m_vd   = sel ? vd16   : vd8;
      m_idx  = sel ? idx16  : idx8;
      m_off  = sel ? off16  : off8;
   end

   task automatic issue(input bit s, input logic [5:0] op,
         input logic [2:0] sw, input logic [9:0] vl, input logic [127:0] a,
         input logic [127:0] b, input logic [127:0] old);
      @(negedge clk);
      sel        = s;
      opcode_in  = op;
      op_type_in = OPT_VV;
      vsew_in    = sw;
      vl_in      = vl;
      vs1_in     = a;
      vs2_in     = b;
      vd_old     = old;
      sb.push_back(model(op, sw, vl, a, b, old, s ? 16 : 8));
      if (s) start16 = 1'b1;
      else   start8  = 1'b1;
   endtask

   // follows the selected DUT to done; bad counts busy/index/offset slips
   task automatic wait_done(input int poke, input logic [2:0] sw,
         output logic [127:0] vd, output logic er, output int runs,
         output int cyc, output int bad);
      int sew, lw, eo;
      sew  = 8 << sw[1:0];
      lw   = sel ? 16 : 8;
      runs = 0;
      cyc  = 0;
      bad  = 0;
      vd   = 'x;
      er   = 1'bx;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 || (poke != 0 && cyc == poke + 1)) begin
            start8  = 1'b0;
            start16 = 1'b0;
         end
         if (poke != 0 && cyc == poke) begin
            if (sel) start16 = 1'b1;
            else     start8  = 1'b1;
            opcode_in = F6_VXOR;
            vl_in     = 10'd1;
            vsew_in   = 3'd1;
            vs1_in    = ~vs1_in;
            vd_old    = ~vd_old;
         end
         if (!m_busy) bad++;
         if (m_run) begin
            eo = (sew > lw) ? (int'(m_idx) % sew) / lw : 0;
            if (int'(m_off) != eo) bad++;
            if (int'(m_idx) != runs * lw) bad++;
            runs++;
         end
         if (m_done) begin
            vd = m_vd;
            er = m_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start8 = 1'b0; start16 = 1'b0;
      opcode_in = '0; op_type_in = '0; vsew_in = '0; vl_in = '0;
      vs1_in = '0; vs2_in = '0; vd_old = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      n_checks++;
      if ({busy8, done8, err8, run8, busy16, done16, err16, run16} !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_ctrl got=%b exp=0", {busy8, done8, err8, run8, busy16, done16, err16, run16});
      end
      n_checks++;
      if ({vd8, vd16, idx8, idx16, off8, off16, nbl8, nbl16} !== '0) begin
         n_errors++;
         $display("FAIL reset_data vd8=%h idx8=%0d off8=%0d nbl8=%0d exp=0", vd8, idx8, off8, nbl8);
      end
   endtask

   task automatic test_vadd8();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      issue(1'b0, F6_VADD, 3'd0, 10'd4, 128'h01010101, 128'h04030201, '1);
      wait_done(0, 3'd0, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (vd !== {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0504_0302} || vd !== e.vd) begin
         n_errors++;
         $display("FAIL vadd8_vd got=%h exp=%h", vd, e.vd);
      end
      n_checks++;
      if (rn !== 4 || cy !== 5 || bd !== 0 || er !== 1'b0) begin
         n_errors++;
         $display("FAIL vadd8_timing runs=%0d done_cyc=%0d bad=%0d err=%b exp 4/5/0/0", rn, cy, bd, er);
      end
      n_checks++;
      if (ot8 !== OPT_VV || op8 !== F6_VADD) begin
         n_errors++;
         $display("FAIL vadd8_fields op_type=%b opcode=%b exp=%b/%b", ot8, op8, OPT_VV, F6_VADD);
      end
   endtask

   task automatic test_carry();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      issue(1'b0, F6_VADD, 3'd1, 10'd1, 128'h0001, 128'h00FF, rnd128());
      wait_done(0, 3'd1, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (vd[15:0] !== 16'h0100 || vd !== e.vd) begin
         n_errors++;
         $display("FAIL carry_vd got=%h exp=%h", vd, e.vd);
      end
      n_checks++;
      if (rn !== 2 || cy !== 3 || bd !== 0) begin
         n_errors++;
         $display("FAIL carry_steps runs=%0d done_cyc=%0d bad=%0d exp 2/3/0", rn, cy, bd);
      end
   endtask

   task automatic test_tail16();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      issue(1'b1, F6_VXOR, 3'd0, 10'd3, 128'h00FFFFFF, 128'h00AA5533, 128'h12345678);
      wait_done(0, 3'd0, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (vd[31:0] !== 32'h1255AACC || vd !== e.vd) begin
         n_errors++;
         $display("FAIL tail16_vd got=%h exp=%h", vd, e.vd);
      end
      n_checks++;
      if (rn !== 2 || cy !== 3 || bd !== 0) begin
         n_errors++;
         $display("FAIL tail16_steps runs=%0d done_cyc=%0d bad=%0d exp 2/3/0", rn, cy, bd);
      end
   endtask

   task automatic test_empty_ops();
      logic [127:0] vd, old;
      logic er;
      int rn, cy, bd;
      exp_t e;
      old = rnd128();
      issue(1'b0, F6_VADD, 3'd0, 10'd0, rnd128(), rnd128(), old);
      wait_done(0, 3'd0, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (rn !== 0 || cy !== 1 || er !== 1'b0 || vd !== e.vd) begin
         n_errors++;
         $display("FAIL vl0 runs=%0d done_cyc=%0d err=%b vd=%h exp 0/1/0/%h", rn, cy, er, vd, e.vd);
      end
      issue(1'b1, F6_VADD, 3'b100, 10'd4, rnd128(), rnd128(), old);
      wait_done(0, 3'b100, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (rn !== 0 || cy !== 1 || er !== e.err || vd !== e.vd) begin
         n_errors++;
         $display("FAIL badsew runs=%0d done_cyc=%0d err=%b exp 0/1/%b", rn, cy, er, e.err);
      end
   endtask

   task automatic test_start_during_run();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      issue(1'b0, F6_VSUB, 3'd0, 10'd8, rnd128(), rnd128(), rnd128());
      wait_done(3, 3'd0, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (vd !== e.vd || rn !== e.runs || cy !== e.runs + 1 || bd !== 0) begin
         n_errors++;
         $display("FAIL restart vd=%h exp=%h runs=%0d exp=%0d bad=%0d", vd, e.vd, rn, e.runs, bd);
      end
      @(negedge clk);
      n_checks++;
      if (busy8 !== 1'b0) begin
         n_errors++;
         $display("FAIL restart_queued busy=%b exp=0", busy8);
      end
   endtask

   task automatic test_reset_mid();
      int dn;
      exp_t e;
      issue(1'b0, F6_VADD, 3'd0, 10'd8, rnd128(), rnd128(), rnd128());
      e = sb.pop_front();
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      n_checks++;
      if ({busy8, done8, run8, err8} !== 4'b0 || vd8 !== '0 || idx8 !== '0 || off8 !== '0) begin
         n_errors++;
         $display("FAIL reset_mid busy=%b done=%b run=%b vd=%h idx=%0d exp all 0", busy8, done8, run8, vd8, idx8);
      end
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) dn++;
      end
      n_checks++;
      if (dn !== 0) begin
         n_errors++;
         $display("FAIL reset_mid_done cycles_busy_or_done=%0d exp=0 (runs=%0d)", dn, e.runs);
      end
   endtask

   task automatic test_clamp();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      issue(1'b0, F6_VADD, 3'd0, 10'd200, rnd128(), rnd128(), rnd128());
      wait_done(0, 3'd0, vd, er, rn, cy, bd);
      e = sb.pop_front();
      n_checks++;
      if (rn !== 16 || cy !== 17 || er !== 1'b0 || bd !== 0 || vd !== e.vd) begin
         n_errors++;
         $display("FAIL clamp runs=%0d done_cyc=%0d err=%b bad=%0d vd=%h exp 16/17/0/0/%h", rn, cy, er, bd, vd, e.vd);
      end
   endtask

   task automatic test_mixed();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      bit         t_sel[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [5:0] t_op[6]  = '{F6_VADD, F6_VSUB, F6_VSUB, F6_VAND, F6_VOR, F6_VADD};
      logic [2:0] t_sw[6]  = '{3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3};
      logic [9:0] t_vl[6]  = '{10'd2, 10'd3, 10'd3, 10'd5, 10'd7, 10'd1};
      for (int i = 0; i < 6; i++) begin
         issue(t_sel[i], t_op[i], t_sw[i], t_vl[i], rnd128(), rnd128(), rnd128());
         wait_done(0, t_sw[i], vd, er, rn, cy, bd);
         e = sb.pop_front();
         n_checks++;
         if (vd !== e.vd || rn !== e.runs || cy !== e.runs + 1 || bd !== 0 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL mixed%0d vd=%h exp=%h runs=%0d exp=%0d cyc=%0d bad=%0d", i, vd, e.vd, rn, e.runs, cy, bd);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] vd;
      logic er;
      int rn, cy, bd;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, (i == 1) ? F6_VXOR : F6_VADD, 3'(i), 10'd4, rnd128(), rnd128(), rnd128());
         wait_done(0, 3'(i), vd, er, rn, cy, bd);
         e = sb.pop_front();
         n_checks++;
         if (vd !== e.vd || rn !== e.runs || cy !== e.runs + 1 || bd !== 0) begin
            n_errors++;
            $display("FAIL b2b%0d vd=%h exp=%h runs=%0d exp=%0d cyc=%0d", i, vd, e.vd, rn, e.runs, cy);
         end
      end
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_vadd8();
      test_carry();
      test_tail16();
      test_empty_ops();
      test_start_during_run();
      test_reset_mid();
      test_clamp();
      test_mixed();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
